panda_lutn: RTL and testbench

//  Parametrised successor of the 5-input LUT: NINP-input truth-table logic block with per-input

---
 rtl/panda_lutn_pkg.sv | 14 +
 rtl/panda_lutn_if.sv | 23 ++
 rtl/panda_lutn_edge_sel.sv | 34 +++
 rtl/panda_lutn.sv | 82 ++++++++
 tb/tb_panda_lutn.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/panda_lutn_pkg.sv
// Shared mode encodings and limits for the NINP-input LUT block.
// No logic; imported by the LUT top, its edge selector and the bench.
package panda_lutn_pkg;

    typedef enum logic [1:0] {
        MODE_LEVEL  = 2'b00,
        MODE_RISE   = 2'b01,
        MODE_FALL   = 2'b10,
        MODE_EITHER = 2'b11
    } mode_e;

    localparam int NINP_MAX = 6;

endpackage

// File: rtl/panda_lutn_if.sv
// Bit-bus side of the LUT block: inputs, modes, table load, stretch and result.
// No handshake; all signals are plain levels sampled on clk_i.
interface panda_lutn_if #(
    parameter int NINP      = 5,
    parameter int STRETCH_W = 16
);
    logic [NINP-1:0]      inp_i;
    logic [2*NINP-1:0]    mode_i;
    logic [(1<<NINP)-1:0] func_i;
    logic                 func_wstb_i;
    logic [STRETCH_W-1:0] stretch_i;
    logic                 out_o;

    modport master (
        output inp_i, mode_i, func_i, func_wstb_i, stretch_i,
        input  out_o
    );

    modport slave (
        input  inp_i, mode_i, func_i, func_wstb_i, stretch_i,
        output out_o
    );
endinterface

// File: rtl/panda_lutn_edge_sel.sv
// Per-input source select: level, rise, fall or either-edge of one bit-bus input.
// Latency: combinational sel from current input and a one-cycle history register.
// Backpressure: none; evaluated every cycle.
module panda_lutn_edge_sel
    import panda_lutn_pkg::*;
(
    input  logic  clk_i,
    input  logic  reset_n_i,
    input  logic  arm,
    input  logic  inp,
    input  mode_e mode,
    output logic  sel
);

    logic prev;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) prev <= 1'b0;
        else            prev <= inp;
    end

    // Edge modes are gated until history holds a real sample, so prev=0 after reset cannot fake an edge.
    always_comb begin
        sel = 1'b0;
        case (mode)
            MODE_LEVEL:  sel = inp;
            MODE_RISE:   sel = arm & inp & ~prev;
            MODE_FALL:   sel = arm & ~inp & prev;
            MODE_EITHER: sel = arm & (inp ^ prev);
            default:     sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/panda_lutn.sv
// NINP-input truth-table block with strobed table load; optional pulse stretch via PANDA_LUTN_STRETCH_EN.
// Latency: 1 clk from inp_i to out_o; table loaded by func_wstb_i is used from the following edge.
// Backpressure: none; out_o updates every cycle.
module panda_lutn
    import panda_lutn_pkg::*;
#(
    parameter int NINP      = 5,
    parameter int STRETCH_W = 16
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    panda_lutn_if.slave bus
);

    localparam int TBL_W = 1 << NINP;

    logic             arm;
    logic [TBL_W-1:0] active_tbl;
    logic [NINP-1:0]  sel;
    logic             lut;
    logic             out_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            arm        <= 1'b0;
            active_tbl <= '0;
        end else begin
            arm <= 1'b1;
            if (bus.func_wstb_i) active_tbl <= bus.func_i;
        end
    end

    for (genvar k = 0; k < NINP; k++) begin : g_sel
        panda_lutn_edge_sel u_edge_sel (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .arm       (arm),
            .inp       (bus.inp_i[k]),
            .mode      (mode_e'(bus.mode_i[2*k+1 -: 2])),
            .sel       (sel[k])
        );
    end

    assign lut = active_tbl[sel];

`ifdef PANDA_LUTN_STRETCH_EN
    logic                 lut_q;
    logic [STRETCH_W-1:0] cnt;

    // cnt holds the extra high cycles still owed after the current one, hence the load of stretch-1.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lut_q <= 1'b0;
            cnt   <= '0;
            out_q <= 1'b0;
        end else begin
            lut_q <= lut;
            if (lut) begin
                out_q <= 1'b1;
                if (!lut_q)
                    cnt <= (bus.stretch_i == '0) ? '0 : bus.stretch_i - STRETCH_W'(1);
            end else if (cnt != '0) begin
                out_q <= 1'b1;
                cnt   <= cnt - STRETCH_W'(1);
            end else begin
                out_q <= 1'b0;
            end
        end
    end
`else
    logic unused_stretch;
    assign unused_stretch = ^bus.stretch_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) out_q <= 1'b0;
        else            out_q <= lut;
    end
`endif

    assign bus.out_o = out_q;

endmodule

// File: tb/tb_panda_lutn.sv
// Directed bench for panda_lutn (NINP=5, STRETCH_W=16); inputs driven and out_o sampled on the falling edge.
module tb_panda_lutn;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;
    logic [6:0] exp_pat;

    always #5 clk = ~clk;

    panda_lutn_if #(.NINP(5), .STRETCH_W(16)) bus ();

    panda_lutn #(.NINP(5), .STRETCH_W(16)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .bus       (bus)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: out_o=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with all inputs high and every input in rise mode
        bus.inp_i       = 5'h1F;
        bus.mode_i      = 10'b01_01_01_01_01;
        bus.func_i      = 32'h0;
        bus.func_wstb_i = 1'b0;
        bus.stretch_i   = 16'd0;
        #2 chk("rst_out", bus.out_o, 1'b0);
        @(negedge clk);
        chk("rst_out_hold", bus.out_o, 1'b0);
        rst_n           = 1'b1;
        bus.func_i      = 32'hFFFF_FFFE;
        bus.func_wstb_i = 1'b1;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        chk("rel_edge1", bus.out_o, 1'b0);
        @(negedge clk);
        chk("rel_edge2", bus.out_o, 1'b0);
        bus.inp_i = 5'h00;
        @(negedge clk);
        chk("rise_fall_none", bus.out_o, 1'b0);
        bus.inp_i = 5'h1F;
        @(negedge clk);
        chk("rise_all", bus.out_o, 1'b1);
        @(negedge clk);
        chk("rise_all_held", bus.out_o, 1'b0);

        // level mode, output follows E
        bus.mode_i      = 10'b0;
        bus.inp_i       = 5'h00;
        bus.func_i      = 32'hFFFF_0000;
        bus.func_wstb_i = 1'b1;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        chk("lvl_load", bus.out_o, 1'b0);
        bus.inp_i = 5'h10;
        @(negedge clk);
        chk("lvl_e_hi", bus.out_o, 1'b1);
        bus.inp_i = 5'h00;
        @(negedge clk);
        chk("lvl_e_lo", bus.out_o, 1'b0);
        bus.inp_i = 5'h0F;
        @(negedge clk);
        chk("lvl_abcd", bus.out_o, 1'b0);
        bus.inp_i = 5'h1F;
        @(negedge clk);
        chk("lvl_all", bus.out_o, 1'b1);

        // A rise then either
        bus.inp_i       = 5'h00;
        bus.mode_i      = 10'b00_00_00_00_01;
        bus.func_i      = 32'hAAAA_AAAA;
        bus.func_wstb_i = 1'b1;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        chk("rise_load", bus.out_o, 1'b0);
        @(negedge clk);
        chk("rise_idle", bus.out_o, 1'b0);
        bus.inp_i = 5'h01;
        @(negedge clk);
        chk("rise_pulse", bus.out_o, 1'b1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("rise_hold%0d", i), bus.out_o, 1'b0);
        end
        bus.mode_i = 10'b00_00_00_00_11;
        bus.inp_i  = 5'h00;
        @(negedge clk);
        chk("either_pulse", bus.out_o, 1'b1);
        @(negedge clk);
        chk("either_after", bus.out_o, 1'b0);

        // table changes only on strobe, new table used one edge later
        bus.mode_i      = 10'b0;
        bus.func_i      = 32'h0;
        bus.func_wstb_i = 1'b1;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        bus.inp_i       = 5'h01;
        bus.func_i      = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("nostb_0", bus.out_o, 1'b0);
        @(negedge clk);
        chk("nostb_1", bus.out_o, 1'b0);
        bus.func_wstb_i = 1'b1;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        chk("stb_old_tbl", bus.out_o, 1'b0);
        @(negedge clk);
        chk("stb_new_tbl", bus.out_o, 1'b1);

        // stretch: single pulse, stretch_i=4
        bus.inp_i       = 5'h00;
        bus.func_i      = 32'hAAAA_AAAA;
        bus.func_wstb_i = 1'b1;
        bus.stretch_i   = 16'd4;
        @(negedge clk);
        bus.func_wstb_i = 1'b0;
        @(negedge clk);
        chk("str_idle", bus.out_o, 1'b0);
`ifdef PANDA_LUTN_STRETCH_EN
        exp_pat = 7'b0001111;
`else
        exp_pat = 7'b0000001;
`endif
        bus.inp_i = 5'h01;
        @(negedge clk);
        bus.inp_i = 5'h00;
        chk("str1_s0", bus.out_o, exp_pat[0]);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("str1_s%0d", i), bus.out_o, exp_pat[i]);
        end

        // retrigger two clocks after first pulse
`ifdef PANDA_LUTN_STRETCH_EN
        exp_pat = 7'b0111111;
`else
        exp_pat = 7'b0000101;
`endif
        bus.inp_i = 5'h01;
        @(negedge clk);
        bus.inp_i = 5'h00;
        chk("str2_s0", bus.out_o, exp_pat[0]);
        @(negedge clk);
        bus.inp_i = 5'h01;
        chk("str2_s1", bus.out_o, exp_pat[1]);
        @(negedge clk);
        bus.inp_i = 5'h00;
        chk("str2_s2", bus.out_o, exp_pat[2]);
        for (int i = 3; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("str2_s%0d", i), bus.out_o, exp_pat[i]);
        end

        // stretch_i=0 behaves as one clock
        bus.stretch_i = 16'd0;
        bus.inp_i     = 5'h01;
        @(negedge clk);
        bus.inp_i = 5'h00;
        chk("str0_s0", bus.out_o, 1'b1);
        @(negedge clk);
        chk("str0_s1", bus.out_o, 1'b0);
        @(negedge clk);
        chk("str0_s2", bus.out_o, 1'b0);

        // async reset in the middle of a stretched pulse
        bus.stretch_i = 16'd4;
        bus.inp_i     = 5'h01;
        @(negedge clk);
        bus.inp_i = 5'h00;
        chk("mid_pre", bus.out_o, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_async", bus.out_o, 1'b0);
        @(negedge clk);
        chk("mid_rst_held", bus.out_o, 1'b0);
        rst_n     = 1'b1;
        bus.inp_i = 5'h01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", i), bus.out_o, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
